// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and memory-mode encodings for the data-memory store buffer.
// Entry fields are sized by SB_ADDR_W/SB_DATA_W; top-level widths must not exceed them.
package dmem_store_buffer_pkg;

  localparam int MEMORY_MODE_WIDTH = 2;
  localparam logic [MEMORY_MODE_WIDTH-1:0] BYTE_MEMORY_MODE = 2'd0;
  localparam logic [MEMORY_MODE_WIDTH-1:0] HALF_MEMORY_MODE = 2'd1;
  localparam logic [MEMORY_MODE_WIDTH-1:0] WORD_MEMORY_MODE = 2'd2;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0]         addr;
    logic [SB_DATA_W-1:0]         data;
    logic [MEMORY_MODE_WIDTH-1:0] mode;
  } sb_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    DRAINING,
    FULL
  } sb_state_t;

  function automatic logic same_word(input logic [SB_ADDR_W-1:0] a,
                                     input logic [SB_ADDR_W-1:0] b);
    return a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular in-order storage for buffered stores with head/tail/count tracking.
// Every slot is exposed so the top can search buffered stores by age.
module sb_fifo
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head_entry,
  output sb_entry_t [DEPTH-1:0]    entries,
  output logic [$clog2(DEPTH)-1:0] head_ptr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] slot_q, slot_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  always_comb begin
    slot_d = slot_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      slot_d[tail_q] = push_entry;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: slots are only read while counted as occupied.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign head_entry = slot_q[head_q];
  assign entries    = slot_q;
  assign head_ptr   = head_q;
  assign count      = count_q;

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and data memory; drains one entry per cycle.
// Define RVMAGIC_STORE_FWD_EN to serve word loads that hit a buffered word store without stalling.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic                         cpu_memRead,
  input  logic                         cpu_memWrite,
  input  logic [MEMORY_MODE_WIDTH-1:0] cpu_memMode,
  input  logic [DATA_WIDTH-1:0]        cpu_dataIn,
  input  logic                         cpu_fence,
  output logic [DATA_WIDTH-1:0]        cpu_dataOut,
  output logic                         cpu_stall,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_memRead,
  output logic                         mem_memWrite,
  output logic [MEMORY_MODE_WIDTH-1:0] mem_memMode,
  output logic [DATA_WIDTH-1:0]        mem_dataIn,
  input  logic [DATA_WIDTH-1:0]        mem_dataOut,
  output logic [$clog2(DEPTH):0]       sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_state_t             state_q, state_d;
  sb_entry_t             push_entry, head_entry;
  sb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      head_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  push, pop, buf_empty, buf_full, fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  unused_sink;

  assign buf_empty  = (state_q == EMPTY);
  assign buf_full   = (state_q == FULL);
  assign push_entry = '{addr: SB_ADDR_W'(cpu_addr), data: SB_DATA_W'(cpu_dataIn), mode: cpu_memMode};
  assign sb_count   = count;
  assign unused_sink = ^{entries, head_ptr};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (entries),
    .head_ptr   (head_ptr),
    .count      (count)
  );

`ifdef RVMAGIC_STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest; the youngest store touching the word decides hit and data.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (cpu_memRead && cpu_memMode == WORD_MEMORY_MODE) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_ptr + PTR_W'(i);
        if (CNT_W'(i) < count && same_word(entries[fwd_idx].addr, SB_ADDR_W'(cpu_addr))) begin
          fwd_hit  = (entries[fwd_idx].mode == WORD_MEMORY_MODE);
          fwd_data = DATA_WIDTH'(entries[fwd_idx].data);
        end
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Reset also blocks the drain so that a discarded head entry never reaches memory.
  always_comb begin
    cpu_stall    = 1'b0;
    cpu_dataOut  = '0;
    mem_addr     = '0;
    mem_memRead  = 1'b0;
    mem_memWrite = 1'b0;
    mem_memMode  = WORD_MEMORY_MODE;
    mem_dataIn   = '0;
    pop          = 1'b0;
    push         = 1'b0;
    if (!rst) begin
      pop = !buf_empty;
      if (cpu_memWrite && buf_full) cpu_stall = 1'b1;
      if (cpu_fence && !buf_empty)  cpu_stall = 1'b1;
      if (cpu_memRead) begin
        if (buf_empty) begin
          mem_memRead = 1'b1;
          mem_addr    = cpu_addr;
          mem_memMode = cpu_memMode;
          cpu_dataOut = mem_dataOut;
        end else if (fwd_hit) begin
          cpu_dataOut = fwd_data;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      if (pop) begin
        mem_memWrite = 1'b1;
        mem_addr     = ADDR_WIDTH'(head_entry.addr);
        mem_dataIn   = DATA_WIDTH'(head_entry.data);
        mem_memMode  = head_entry.mode;
      end
      push = cpu_memWrite && !cpu_stall;
    end
  end

  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    if (count_next == '0) begin
      state_d = EMPTY;
    end else if (count_next == CNT_W'(DEPTH)) begin
      state_d = FULL;
    end else begin
      state_d = DRAINING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench: randomized and directed traffic against a queue-based store buffer model.
`timescale 1ns/1ps
module tb_dmem_store_buffer;
  import dmem_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_dataIn, cpu_dataOut;
  logic        cpu_memRead, cpu_memWrite, cpu_fence, cpu_stall;
  logic [1:0]  cpu_memMode, mem_memMode;
  logic [31:0] mem_addr, mem_dataIn, mem_dataOut;
  logic        mem_memRead, mem_memWrite;
  logic [2:0]  sb_count;

  dmem_store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_memRead(cpu_memRead),
    .cpu_memWrite(cpu_memWrite), .cpu_memMode(cpu_memMode), .cpu_dataIn(cpu_dataIn),
    .cpu_fence(cpu_fence), .cpu_dataOut(cpu_dataOut), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_memMode(mem_memMode), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
    .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  // Physical byte-addressed memory, little-endian, reads zero-extended.
  logic [7:0] phys [0:1023];
  always @(posedge clk) begin
    if (mem_memWrite) begin
      if (mem_memMode == BYTE_MEMORY_MODE) phys[mem_addr[9:0]] <= mem_dataIn[7:0];
      else if (mem_memMode == HALF_MEMORY_MODE) begin
        phys[{mem_addr[9:1], 1'b0}] <= mem_dataIn[7:0];
        phys[{mem_addr[9:1], 1'b1}] <= mem_dataIn[15:8];
      end else for (int b = 0; b < 4; b++) phys[{mem_addr[9:2], 2'(b)}] <= mem_dataIn[8*b +: 8];
    end
  end
  always_comb begin
    if (mem_memMode == BYTE_MEMORY_MODE) mem_dataOut = {24'b0, phys[mem_addr[9:0]]};
    else if (mem_memMode == HALF_MEMORY_MODE)
      mem_dataOut = {16'b0, phys[{mem_addr[9:1], 1'b1}], phys[{mem_addr[9:1], 1'b0}]};
    else mem_dataOut = {phys[{mem_addr[9:2], 2'd3}], phys[{mem_addr[9:2], 2'd2}],
                        phys[{mem_addr[9:2], 2'd1}], phys[{mem_addr[9:2], 2'd0}]};
  end

  // Reference model: committed words plus an ordered queue of pending stores.
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] mode; } st_t;
  st_t         q[$];
  logic [31:0] cm [int];
  int total = 0, bad = 0, g_perr = 0, g_tout = 0, maxcnt = 0;

  function automatic logic [31:0] get_cm(input logic [31:0] a);
    return cm.exists(int'(a[31:2])) ? cm[int'(a[31:2])] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                        input logic [1:0] m, input logic [31:0] d);
    logic [31:0] r = w;
    if (m == BYTE_MEMORY_MODE) r[8*a[1:0] +: 8] = d[7:0];
    else if (m == HALF_MEMORY_MODE) r[16*a[1] +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction

  // Value the core should observe: committed memory with every pending store applied in order.
  function automatic logic [31:0] arch_read(input logic [31:0] a, input logic [1:0] m);
    logic [31:0] w = get_cm(a);
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) w = merge(w, q[i].addr, q[i].mode, q[i].data);
    if (m == BYTE_MEMORY_MODE) return {24'b0, w[8*a[1:0] +: 8]};
    if (m == HALF_MEMORY_MODE) return {16'b0, w[16*a[1] +: 16]};
    return w;
  endfunction

  function automatic logic model_hit(input logic [31:0] a, input logic [1:0] m);
    logic h = 1'b0;
`ifdef RVMAGIC_STORE_FWD_EN
    if (m == WORD_MEMORY_MODE)
      foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) h = (q[i].mode == WORD_MEMORY_MODE);
`else
    h = 1'b0;
`endif
    return h;
  endfunction

  function automatic logic [31:0] phys_word(input int a);
    return {phys[a+3], phys[a+2], phys[a+1], phys[a]};
  endfunction

  // Holds one request until the DUT accepts it; starts and ends 1 ns after a rising edge.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] m,
                        input logic [31:0] d, input logic fn,
                        output int stalls, output int mstalls, output logic [31:0] dout);
    int n; logic es, served;
    stalls = 0; mstalls = 0; dout = '0;
    cpu_memRead = rd; cpu_memWrite = wr; cpu_addr = a; cpu_memMode = m; cpu_dataIn = d; cpu_fence = fn;
    forever begin
      n  = q.size();
      es = (wr && n == DEPTH) || (fn && n > 0) || (rd && n > 0 && !model_hit(a, m));
      @(negedge clk);
      if (cpu_stall !== es) g_perr++;
      if (mem_memWrite !== (n > 0)) g_perr++;
      if (n > 0 && (mem_addr !== q[0].addr || mem_dataIn !== q[0].data || mem_memMode !== q[0].mode)) g_perr++;
      if (mem_memRead !== (rd && n == 0)) g_perr++;
      if (n == 0 && !rd && (mem_addr !== 32'h0 || mem_memMode !== WORD_MEMORY_MODE)) g_perr++;
      if (sb_count !== 3'(n)) g_perr++;
      if (!rd && cpu_dataOut !== 32'h0) g_perr++;
      if (n > maxcnt) maxcnt = n;
      if (es) mstalls++;
      served = !cpu_stall;
      if (rd && served) dout = cpu_dataOut;
      @(posedge clk);
      if (n > 0) begin
        cm[int'(q[0].addr[31:2])] = merge(get_cm(q[0].addr), q[0].addr, q[0].mode, q[0].data);
        void'(q.pop_front());
      end
      if (wr && !es) q.push_back('{a, d, m});
      #1;
      if (served) break;
      stalls++;
      if (stalls > 20) begin g_tout++; break; end
    end
    cpu_memRead = 0; cpu_memWrite = 0; cpu_fence = 0; cpu_addr = 0; cpu_dataIn = 0;
    cpu_memMode = WORD_MEMORY_MODE;
  endtask

  task automatic nops(input int k);
    int s, ms; logic [31:0] d;
    for (int i = 0; i < k; i++) run_op(0, 0, 0, WORD_MEMORY_MODE, 0, 0, s, ms, d);
  endtask

  task automatic test_reset;
    rst = 1; cpu_memRead = 0; cpu_memWrite = 0; cpu_fence = 0; cpu_addr = 0; cpu_dataIn = 0;
    cpu_memMode = WORD_MEMORY_MODE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", sb_count); end
    total++; if (mem_memWrite !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b want=0", mem_memWrite); end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", cpu_stall); end
    total++; if (mem_memRead !== 1'b0) begin bad++; $display("FAIL idle_memread got=%b want=0", mem_memRead); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL idle_addr got=%h want=0", mem_addr); end
    total++; if (mem_memMode !== WORD_MEMORY_MODE) begin bad++; $display("FAIL idle_mode got=%0d want=%0d", mem_memMode, WORD_MEMORY_MODE); end
    total++; if (cpu_dataOut !== 32'h0 || mem_dataIn !== 32'h0) begin bad++; $display("FAIL idle_data got=%h/%h want=0/0", cpu_dataOut, mem_dataIn); end
    @(posedge clk); #1;
  endtask

  task automatic test_stores_then_load;
    int s, ms, acc; logic [31:0] d, exp; logic [31:0] dat [4];
    g_perr = 0; g_tout = 0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = $urandom;
      run_op(0, 1, 32'h100 + 32'(4*i), WORD_MEMORY_MODE, dat[i], 0, s, ms, d);
      acc += s;
    end
    total++; if (acc !== 0) begin bad++; $display("FAIL t1_store_stall got=%0d want=0", acc); end
    exp = model_hit(32'h100, WORD_MEMORY_MODE) ? 0 : q.size();
    run_op(1, 0, 32'h100, WORD_MEMORY_MODE, 0, 0, s, ms, d);
    total++; if (s !== int'(exp)) begin bad++; $display("FAIL t1_load_stall got=%0d want=%0d", s, exp); end
    total++; if (d !== dat[0]) begin bad++; $display("FAIL t1_load_data got=%h want=%h", d, dat[0]); end
    nops(2);
    acc = 0;
    for (int i = 0; i < 4; i++) if (phys_word(256 + 4*i) !== dat[i]) acc++;
    total++; if (acc !== 0) begin bad++; $display("FAIL t1_mem_words got=%0d_wrong want=0_wrong", acc); end
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t1_port got=%0d/%0d want=0/0", g_perr, g_tout); end
  endtask

  task automatic test_back_to_back;
    int s, ms, acc, macc; logic [31:0] d;
    g_perr = 0; g_tout = 0; acc = 0; macc = 0; maxcnt = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(0, 1, 32'h180 + 32'(4*i), WORD_MEMORY_MODE, $urandom, 0, s, ms, d);
      acc += s; macc += ms;
    end
    nops(2);
    total++; if (acc !== macc) begin bad++; $display("FAIL t2_stalls got=%0d want=%0d", acc, macc); end
    total++; if (maxcnt > DEPTH) begin bad++; $display("FAIL t2_maxcount got=%0d want<=%0d", maxcnt, DEPTH); end
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t2_port got=%0d/%0d want=0/0", g_perr, g_tout); end
  endtask

  task automatic test_forward;
    int s, ms, want_s; logic [31:0] d;
    g_perr = 0; g_tout = 0;
`ifdef RVMAGIC_STORE_FWD_EN
    want_s = 0;
`else
    want_s = 1;
`endif
    run_op(0, 1, 32'h200, WORD_MEMORY_MODE, 32'hDEADBEEF, 0, s, ms, d);
    run_op(1, 0, 32'h200, WORD_MEMORY_MODE, 0, 0, s, ms, d);
    total++; if (s !== want_s) begin bad++; $display("FAIL t3_stall got=%0d want=%0d", s, want_s); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL t3_data got=%h want=deadbeef", d); end
    nops(2);
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t3_port got=%0d/%0d want=0/0", g_perr, g_tout); end
  endtask

  task automatic test_byte_merge;
    int s, ms; logic [31:0] d;
    g_perr = 0; g_tout = 0;
    run_op(0, 1, 32'h300, WORD_MEMORY_MODE, 32'h11223344, 0, s, ms, d);
    nops(1);
    run_op(0, 1, 32'h301, BYTE_MEMORY_MODE, 32'h000000AB, 0, s, ms, d);
    run_op(1, 0, 32'h300, WORD_MEMORY_MODE, 0, 0, s, ms, d);
    total++; if (s !== 1) begin bad++; $display("FAIL t4_stall got=%0d want=1", s); end
    total++; if (d !== 32'h1122AB44) begin bad++; $display("FAIL t4_data got=%h want=1122ab44", d); end
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t4_port got=%0d/%0d want=0/0", g_perr, g_tout); end
  endtask

  task automatic test_fence;
    int s, ms, n; logic [31:0] d;
    g_perr = 0; g_tout = 0;
    for (int i = 0; i < 3; i++) run_op(0, 1, 32'h3C0 + 32'(4*i), WORD_MEMORY_MODE, $urandom, 0, s, ms, d);
    n = q.size();
    run_op(0, 0, 0, WORD_MEMORY_MODE, 0, 1, s, ms, d);
    total++; if (s !== n) begin bad++; $display("FAIL t5_fence_stall got=%0d want=%0d", s, n); end
    total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL t5_count got=%0d want=0", sb_count); end
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t5_port got=%0d/%0d want=0/0", g_perr, g_tout); end
  endtask

  task automatic test_reset_mid;
    int s, ms; logic [31:0] d;
    g_perr = 0; g_tout = 0;
    run_op(0, 1, 32'h244, WORD_MEMORY_MODE, 32'h55AA55AA, 0, s, ms, d);
    nops(1);
    run_op(0, 1, 32'h240, WORD_MEMORY_MODE, 32'h12345678, 0, s, ms, d);
    run_op(0, 1, 32'h244, WORD_MEMORY_MODE, 32'hCAFEF00D, 0, s, ms, d);
    rst = 1;
    @(negedge clk);
    total++; if (mem_memWrite !== 1'b0) begin bad++; $display("FAIL t6_rst_write got=%b want=0", mem_memWrite); end
    @(posedge clk);
    q.delete();
    #1 rst = 0;
    total++; if (sb_count !== 3'd0) begin bad++; $display("FAIL t6_count got=%0d want=0", sb_count); end
    @(negedge clk);
    total++; if (mem_memWrite !== 1'b0) begin bad++; $display("FAIL t6_after_write got=%b want=0", mem_memWrite); end
    total++; if (phys_word(32'h244) !== get_cm(32'h244)) begin bad++; $display("FAIL t6_discard got=%h want=%h", phys_word(32'h244), get_cm(32'h244)); end
    total++; if (phys_word(32'h240) !== 32'h12345678) begin bad++; $display("FAIL t6_committed got=%h want=12345678", phys_word(32'h240)); end
    total++; if (g_perr !== 0 || g_tout !== 0) begin bad++; $display("FAIL t6_port got=%0d/%0d want=0/0", g_perr, g_tout); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int s, ms, r, ld_bad, mem_bad; logic [31:0] a, d, exp; logic [1:0] m;
    g_perr = 0; g_tout = 0; ld_bad = 0; mem_bad = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      m = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63)) * 4;
      if (m == BYTE_MEMORY_MODE) a = a + 32'($urandom_range(0, 3));
      else if (m == HALF_MEMORY_MODE) a = a + 32'($urandom_range(0, 1)) * 2;
      if (r <= 4) run_op(0, 1, a, m, $urandom, 0, s, ms, d);
      else if (r <= 7) begin
        exp = arch_read(a, m);
        run_op(1, 0, a, m, 0, 0, s, ms, d);
        if (d !== exp) ld_bad++;
      end else if (r == 8) run_op(0, 0, 0, WORD_MEMORY_MODE, 0, 1, s, ms, d);
      else nops(1);
    end
    nops(2);
    for (int w = 0; w < 256; w++) if (phys_word(4*w) !== get_cm(32'(4*w))) mem_bad++;
    total++; if (ld_bad !== 0) begin bad++; $display("FAIL rnd_load got=%0d_wrong want=0_wrong", ld_bad); end
    total++; if (mem_bad !== 0) begin bad++; $display("FAIL rnd_memory got=%0d_wrong want=0_wrong", mem_bad); end
    total++; if (g_perr !== 0) begin bad++; $display("FAIL rnd_port got=%0d want=0", g_perr); end
    total++; if (g_tout !== 0) begin bad++; $display("FAIL rnd_timeout got=%0d want=0", g_tout); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) phys[i] = 8'h00;
    test_reset;
    test_stores_then_load;
    test_back_to_back;
    test_forward;
    test_byte_merge;
    test_fence;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
